// File: rtl/accu_mod_multi_if.sv
// ============================================================================
// Module : accu_mod_multi_if
// Purpose: Bus bundle for accu_mod_multi: sample input, registered result,
//          sticky per-channel flags and the combinational readback port.
// Ports  : in_valid/in_ch/d   sample toward the accumulator
//          out_valid/out_ch/acc/wrap  registered result of the last sample
//          ovf                 per-channel sticky wrap/clamp flags
//          rd_ch/rd_acc        readback select and stored value
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface accu_mod_multi_if #(
  parameter int W  = 16,
  parameter int CH = 4,
  parameter int CW = (CH > 1) ? $clog2(CH) : 1
);
  logic          in_valid;
  logic [CW-1:0] in_ch;
  logic [W-1:0]  d;
  logic          out_valid;
  logic [CW-1:0] out_ch;
  logic [W-1:0]  acc;
  logic          wrap;
  logic [CH-1:0] ovf;
  logic [CW-1:0] rd_ch;
  logic [W-1:0]  rd_acc;

  modport master (
    output in_valid, in_ch, d, rd_ch,
    input  out_valid, out_ch, acc, wrap, ovf, rd_acc
  );

  modport slave (
    input  in_valid, in_ch, d, rd_ch,
    output out_valid, out_ch, acc, wrap, ovf, rd_acc
  );
endinterface

`default_nettype wire

// File: rtl/accu_mod_multi.sv
// ============================================================================
// Module : accu_mod_multi
// Purpose: CH independent accumulators sharing one adder. Each sample adds d
//          to the selected channel; the result wraps modulo Meff (SAT=0) or
//          clamps at Meff-1 (SAT=1), where Meff = M, or 2^W when M = 0.
// Ports  : clk    rising-edge clock
//          rst_n  asynchronous active-low reset
//          clr    synchronous clear of all channels and sticky flags
//          bus    accu_mod_multi_if.slave (sample in, result out, readback)
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module accu_mod_multi #(
  parameter int W   = 16,
  parameter int CH  = 4,
  parameter int M   = 50,
  parameter int SAT = 0
) (
  input wire logic         clk,
  input wire logic         rst_n,
  input wire logic         clr,
  accu_mod_multi_if.slave  bus
);
  localparam int         CW   = (CH > 1) ? $clog2(CH) : 1;
  // Register file is sized to the full select range so any in_ch/rd_ch
  // indexes a real entry; entries at or above CH are never written.
  localparam int         NREG = 1 << CW;
  localparam logic [W:0] MEFF = (M == 0) ? {1'b1, {W{1'b0}}} : (W+1)'(M);
  localparam logic [W:0] MAXV = MEFF - 1'b1;
  localparam logic [CW:0] CH_L = (CW+1)'(CH);

  logic [W-1:0]  regs [NREG];
  logic          out_valid_r;
  logic [CW-1:0] out_ch_r;
  logic [W-1:0]  acc_r;
  logic          wrap_r;
  logic [CH-1:0] ovf_r;

  logic          take;
  logic [W-1:0]  cur;
  logic [W:0]    s_full;
  logic          hit_wrap;
  logic [W-1:0]  nxt;
  logic [CH-1:0] ch_hit;

  assign take     = bus.in_valid && !clr && ({1'b0, bus.in_ch} < CH_L);
  assign cur      = regs[bus.in_ch];
  // Exact sum of the raw addend; it alone decides the wrap/clamp flag.
  assign s_full   = {1'b0, cur} + {1'b0, bus.d};
  assign hit_wrap = (s_full >= MEFF);

  generate
    if (SAT != 0) begin : g_sat
      assign nxt = hit_wrap ? MAXV[W-1:0] : s_full[W-1:0];
    end else begin : g_wrap
      logic [W:0] d_red;
      logic [W:0] s_red;
      // Reducing d first bounds the sum below 2*Meff, so one conditional
      // subtract completes the modulo for any addend.
      assign d_red = {1'b0, bus.d} % MEFF;
      assign s_red = {1'b0, cur} + d_red;
      assign nxt   = (s_red >= MEFF) ? W'(s_red - MEFF) : s_red[W-1:0];
    end
  endgenerate

  generate
    for (genvar i = 0; i < CH; i++) begin : g_hit
      assign ch_hit[i] = take && (bus.in_ch == CW'(i));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (take) begin
      regs[bus.in_ch] <= nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_ch_r    <= '0;
      acc_r       <= '0;
      wrap_r      <= 1'b0;
      ovf_r       <= '0;
    end else if (clr) begin
      out_valid_r <= 1'b0;
      wrap_r      <= 1'b0;
      ovf_r       <= '0;
    end else if (take) begin
      out_valid_r <= 1'b1;
      out_ch_r    <= bus.in_ch;
      acc_r       <= nxt;
      wrap_r      <= hit_wrap;
      ovf_r       <= ovf_r | (ch_hit & {CH{hit_wrap}});
    end else begin
      // Idle or out-of-range channel: result port holds acc/out_ch.
      out_valid_r <= 1'b0;
      wrap_r      <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.out_ch    = out_ch_r;
  assign bus.acc       = acc_r;
  assign bus.wrap      = wrap_r;
  assign bus.ovf       = ovf_r;
  assign bus.rd_acc    = ({1'b0, bus.rd_ch} < CH_L) ? regs[bus.rd_ch] : '0;
endmodule

`default_nettype wire

// File: tb/tb_accu_mod_multi.sv
// ============================================================================
// Module : tb_accu_mod_multi
// Purpose: Self-checking bench for accu_mod_multi across five configurations:
//          k0 W16 CH4 M50 wrap, k1 W16 CH4 M50 sat, k2 W16 CH3 M0 sat,
//          k3 W16 CH1 M0 wrap, k4 W6 CH1 M50 wrap.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_accu_mod_multi;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  accu_mod_multi_if #(.W(16), .CH(4)) if0 ();
  accu_mod_multi_if #(.W(16), .CH(4)) if1 ();
  accu_mod_multi_if #(.W(16), .CH(3)) if2 ();
  accu_mod_multi_if #(.W(16), .CH(1)) if3 ();
  accu_mod_multi_if #(.W(6),  .CH(1)) if4 ();

  accu_mod_multi #(.W(16), .CH(4), .M(50), .SAT(0)) dut0 (.clk(clk), .rst_n(rst_n), .clr(clr), .bus(if0));
  accu_mod_multi #(.W(16), .CH(4), .M(50), .SAT(1)) dut1 (.clk(clk), .rst_n(rst_n), .clr(clr), .bus(if1));
  accu_mod_multi #(.W(16), .CH(3), .M(0),  .SAT(1)) dut2 (.clk(clk), .rst_n(rst_n), .clr(clr), .bus(if2));
  accu_mod_multi #(.W(16), .CH(1), .M(0),  .SAT(0)) dut3 (.clk(clk), .rst_n(rst_n), .clr(clr), .bus(if3));
  accu_mod_multi #(.W(6),  .CH(1), .M(50), .SAT(0)) dut4 (.clk(clk), .rst_n(rst_n), .clr(clr), .bus(if4));

  int cfg_w   [5] = '{16, 16, 16, 16, 6};
  int cfg_ch  [5] = '{4, 4, 3, 1, 1};
  int cfg_m   [5] = '{50, 50, 0, 0, 50};
  int cfg_sat [5] = '{0, 1, 1, 0, 0};

  // Reference model: plain arithmetic on the accumulation rules.
  longint mreg [5][4];
  longint movf [5];
  longint mov  [5];
  longint moch [5];
  longint macc [5];
  longint mwrap[5];

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int ch;
    int d;
    int acc_w;
    int wrap_w;
    int acc_s;
    int wrap_s;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(string nm, longint act, longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 4; i++) mreg[k][i] = 0;
      movf[k] = 0; mov[k] = 0; moch[k] = 0; macc[k] = 0; mwrap[k] = 0;
    end
  endtask

  task automatic model_step(int k, bit v, int ch, longint d, bit c);
    longint meff, s, dm, nv;
    meff = (cfg_m[k] == 0) ? (longint'(1) << cfg_w[k]) : longint'(cfg_m[k]);
    dm   = d & ((longint'(1) << cfg_w[k]) - 1);
    if (c) begin
      for (int i = 0; i < 4; i++) mreg[k][i] = 0;
      movf[k] = 0; mov[k] = 0; mwrap[k] = 0;
    end else if (v && ch < cfg_ch[k]) begin
      s = mreg[k][ch] + dm;
      if (cfg_sat[k] != 0) nv = (s > meff - 1) ? meff - 1 : s;
      else                 nv = s % meff;
      mwrap[k]    = (s >= meff) ? 1 : 0;
      mreg[k][ch] = nv;
      mov[k]      = 1;
      moch[k]     = ch;
      macc[k]     = nv;
      movf[k]     = movf[k] | (mwrap[k] << ch);
    end else begin
      mov[k] = 0; mwrap[k] = 0;
    end
  endtask

  task automatic check_dut(int k, logic ov, longint och, longint acc, logic wr,
                           longint ovf, longint rdacc, int rdch);
    chk($sformatf("k%0d out_valid", k), longint'(ov), mov[k]);
    chk($sformatf("k%0d out_ch", k), och, moch[k]);
    chk($sformatf("k%0d acc", k), acc, macc[k]);
    chk($sformatf("k%0d wrap", k), longint'(wr), mwrap[k]);
    chk($sformatf("k%0d ovf", k), ovf, movf[k]);
    chk($sformatf("k%0d rd_acc[%0d]", k, rdch), rdacc,
        (rdch < cfg_ch[k]) ? mreg[k][rdch] : 0);
  endtask

  task automatic check_all(int rda);
    check_dut(0, if0.out_valid, if0.out_ch, if0.acc, if0.wrap, if0.ovf, if0.rd_acc, rda);
    check_dut(1, if1.out_valid, if1.out_ch, if1.acc, if1.wrap, if1.ovf, if1.rd_acc, rda);
    check_dut(2, if2.out_valid, if2.out_ch, if2.acc, if2.wrap, if2.ovf, if2.rd_acc, rda);
    check_dut(3, if3.out_valid, if3.out_ch, if3.acc, if3.wrap, if3.ovf, if3.rd_acc, 0);
    check_dut(4, if4.out_valid, if4.out_ch, if4.acc, if4.wrap, if4.ovf, if4.rd_acc, 0);
  endtask

  task automatic set_rd(int r);
    if0.rd_ch = 2'(r); if1.rd_ch = 2'(r); if2.rd_ch = 2'(r);
  endtask

  task automatic drive(bit va, int cha, longint da, bit vb, longint db, bit c, int rda);
    if0.in_valid = va; if0.in_ch = 2'(cha); if0.d = 16'(da);
    if1.in_valid = va; if1.in_ch = 2'(cha); if1.d = 16'(da);
    if2.in_valid = va; if2.in_ch = 2'(cha); if2.d = 16'(da);
    if3.in_valid = vb; if3.in_ch = 1'b0;    if3.d = 16'(db);
    if4.in_valid = vb; if4.in_ch = 1'b0;    if4.d = 6'(db);
    set_rd(rda);
    clr = c;
  endtask

  // One clock: drive, advance the model on the edge, compare just after it.
  task automatic apply(bit va, int cha, longint da, bit vb, longint db, bit c, int rda);
    drive(va, cha, da, vb, db, c, rda);
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_step(k, va, cha, da, c);
    for (int k = 3; k < 5; k++) model_step(k, vb, 0, db, c);
    #1;
    check_all(rda);
  endtask

  initial begin
    longint sum_b;
    int rda;
    tbl[0] = '{ch: 1, d: 30, acc_w: 30, wrap_w: 0, acc_s: 30, wrap_s: 0};
    tbl[1] = '{ch: 1, d: 30, acc_w: 10, wrap_w: 1, acc_s: 49, wrap_s: 1};
    tbl[2] = '{ch: 1, d: 63, acc_w: 23, wrap_w: 1, acc_s: 49, wrap_s: 1};
    tbl[3] = '{ch: 2, d: 30, acc_w: 30, wrap_w: 0, acc_s: 30, wrap_s: 0};
    tbl[4] = '{ch: 2, d: 30, acc_w: 10, wrap_w: 1, acc_s: 49, wrap_s: 1};
    tbl[5] = '{ch: 2, d: 5,  acc_w: 15, wrap_w: 0, acc_s: 49, wrap_s: 1};

    if3.rd_ch = 1'b0;
    if4.rd_ch = 1'b0;
    model_reset();

    // Reset held 3 cycles with a valid sample pending.
    drive(1'b1, 0, 5, 1'b1, 5, 1'b0, 0);
    repeat (3) begin
      @(posedge clk);
      #1;
      check_all(0);
    end
    rst_n = 1'b1;

    apply(1'b1, 0, 7, 1'b0, 0, 1'b0, 0);
    chk("first_after_rst acc", if0.acc, 7);

    // Directed wrap/saturate vectors.
    for (int i = 0; i < 6; i++) begin
      apply(1'b1, tbl[i].ch, tbl[i].d, 1'b0, 0, 1'b0, tbl[i].ch);
      chk($sformatf("tbl%0d wrap-mode acc", i), if0.acc, tbl[i].acc_w);
      chk($sformatf("tbl%0d wrap-mode flag", i), if0.wrap, tbl[i].wrap_w);
      chk($sformatf("tbl%0d sat-mode acc", i), if1.acc, tbl[i].acc_s);
      chk($sformatf("tbl%0d sat-mode flag", i), if1.wrap, tbl[i].wrap_s);
      if (i == 2) chk("ovf after ch1 seq", if0.ovf, 4'b0010);
    end
    chk("sat ovf", if1.ovf, 4'b0110);

    // Channel independence, back-to-back.
    apply(1'b0, 0, 0, 1'b0, 0, 1'b1, 0);
    for (int i = 0; i < 10; i++) begin
      apply(1'b1, (i % 2 == 1) ? 3 : 0, (i % 2 == 1) ? 2 : 1, 1'b0, 0, 1'b0, 0);
      chk("indep out_valid", if0.out_valid, 1);
      chk("indep out_ch", if0.out_ch, (i % 2 == 1) ? 3 : 0);
    end
    set_rd(0); #1; chk("indep rd ch0", if0.rd_acc, 5);
    set_rd(3); #1; chk("indep rd ch3", if0.rd_acc, 10);

    // clr colliding with a valid sample.
    apply(1'b1, 1, 10, 1'b0, 0, 1'b0, 1);
    apply(1'b1, 1, 4, 1'b0, 0, 1'b1, 1);
    chk("clr out_valid", if0.out_valid, 0);
    chk("clr ovf", if0.ovf, 0);
    for (int c = 0; c < 4; c++) begin
      set_rd(c); #1;
      chk($sformatf("clr rd ch%0d", c), if0.rd_acc, 0);
    end
    apply(1'b1, 1, 4, 1'b0, 0, 1'b0, 1);
    chk("post-clr acc", if0.acc, 4);

    // Single-channel equivalence: running sum modulo 2^16 and modulo 50.
    sum_b = 0;
    for (int i = 0; i < 40; i++) begin
      apply(1'b0, 0, 0, 1'b1, i, 1'b0, 0);
      sum_b += i;
      chk("eq M0 W16", if3.acc, sum_b % 65536);
      chk("eq M50 W6", if4.acc, sum_b % 50);
    end

    // Randomised traffic with an asynchronous reset mid-stream.
    rda = 0;
    for (int i = 0; i < 400; i++) begin
      bit va, vb, c;
      int cha;
      longint da, db;
      va  = ($urandom_range(0, 3) != 0);
      vb  = ($urandom_range(0, 3) != 0);
      cha = $urandom_range(0, 3);
      da  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 65535) : $urandom_range(0, 60);
      db  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 65535) : $urandom_range(0, 63);
      c   = ($urandom_range(0, 49) == 0);
      rda = $urandom_range(0, 3);
      apply(va, cha, da, vb, db, c, rda);
      if (i == 200) begin
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_all(rda);
        @(posedge clk);
        #1;
        check_all(rda);
        rst_n = 1'b1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/accu_mod_multi.md
Name: accu_mod_multi

Overview:
- Multi-channel modulo/saturating accumulator. Generalises the single-channel wrapping accumulator and the fixed-modulus accumulator into one block.
- Holds CH independent accumulators, with a per-cycle channel select and a valid-qualified input.
- Each channel either wraps modulo M or saturates at M-1.
- Used in counter, phase and histogram datapaths that need several running sums sharing one adder.

Parameters:
- W, 16: data and accumulator width, in bits.
- CH, 4: number of channels; CH >= 1.
- M, 50: modulus. 0 means 2^W (natural wrap). If nonzero, 2 <= M <= 2^W.
- SAT, 0: mode. 0 = wrap modulo M; 1 = saturate at M-1 (or 2^W-1 when M=0).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  synchronous clear of all channels and sticky flags
- in_valid  in  1  input sample valid
- in_ch  in  CW  target channel, where CW = max(1, clog2(CH))
- d  in  W  addend, unsigned; any value 0..2^W-1 is legal, including d >= M
- out_valid  out  1  result valid, registered
- out_ch  out  CW  channel of the result
- acc  out  W  updated accumulator value of out_ch
- wrap  out  1  this result wrapped (SAT=0) or clamped (SAT=1)
- ovf  out  CH  per-channel sticky wrap/clamp flag
- rd_ch  in  CW  readback select
- rd_acc  out  W  combinational readback of the stored value of rd_ch

Behaviour:
- Reset (rst_n low, asynchronous):
  - all channel registers = 0;
  - out_valid = 0, out_ch = 0, acc = 0, wrap = 0, ovf = 0.
  - Reset applies immediately, even mid-stream; no pending result survives.
- Update on a rising edge with in_valid=1, clr=0, in_ch < CH:
  - Compute s = reg[in_ch] + d exactly, in W+1 bits.
  - SAT=0: reg[in_ch] <= s mod Meff, where Meff = M, or 2^W if M=0. wrap = (s >= Meff).
  - SAT=1: reg[in_ch] <= min(s, Meff-1). wrap = (s > Meff-1).
  - The result must be exact for d >= M. (s mod Meff) needs at most one combinational reduction of the sum; d itself must be pre-reduced mod Meff when d >= Meff.
  - Same edge: out_valid <= 1, out_ch <= in_ch, acc <= new reg value, wrap <= computed flag, ovf[in_ch] <= ovf[in_ch] | wrap.
- Latency:
  - exactly 1 cycle from an in_valid sample to out_valid;
  - full throughput, one update per cycle;
  - back-to-back updates to the same channel use the just-written value (no hazard, since the register file is written every edge).
- Idle cycles (in_valid=0): out_valid <= 0, wrap <= 0. acc and out_ch hold their last values. Registers are unchanged.
- clr:
  - Highest priority after reset: all regs <= 0, ovf <= 0, out_valid <= 0, wrap <= 0.
  - A simultaneous in_valid sample is discarded.
- in_ch >= CH (non-power-of-2 CH): the sample is ignored and out_valid <= 0. No state changes.
- rd_acc = reg[rd_ch], combinational from the registers, so it reflects the update one edge after the sample. rd_ch >= CH returns 0.
- Invariants:
  - every reg < Meff at all times;
  - with CH=1, M=50, SAT=0, en held high, the acc sequence equals (running sum of d) mod 50 each cycle.
- Reset-mid-operation recovery: the first valid after rst_n rises accumulates from 0.

Test Plan:
- Reset and idle:
  - Stimulus: hold rst_n low 3 cycles with in_valid=1, then release.
  - Response: during reset out_valid=0, acc=0, ovf=0. The first sample after release with d=7 on ch0 gives acc=7 one cycle later.
- Wrap mode, M=50, SAT=0, ch1:
  - Stimulus: d=30, 30, 63.
  - Response: acc=30 (wrap=0), 10 (wrap=1), 23 (wrap=1). ovf=0b0010.
- Saturate mode, M=50, SAT=1, ch2:
  - Stimulus: d=30, 30, 5.
  - Response: acc=30 (wrap=0), 49 (wrap=1), 49 (wrap=1). ovf[2]=1.
- Channel independence:
  - Stimulus: interleave ch0 d=1 and ch3 d=2 for 10 cycles back-to-back.
  - Response: final rd_acc(ch0)=5, rd_acc(ch3)=10. out_ch alternates 0/3 and out_valid is held high.
- clr collision:
  - Stimulus: with ch1=10, assert clr and in_valid(ch1, d=4) on the same edge.
  - Response: next cycle out_valid=0, all regs=0, ovf=0. A following d=4 gives acc=4.
- Equivalence regression, CH=1, M=0, W=16 vs M=50, W=6:
  - Stimulus: d incrementing from 0 every cycle for 40 cycles.
  - Response: every cycle, acc == (sum of d) mod 2^16 for the first configuration and mod 50 for the second. The bench asserts this each cycle.
